// File: rtl/uart_receiver_if.sv
// Signal bundle between the UART receiver and its environment:
// serial line and baud tick in, received byte and status strobes out.
interface uart_receiver_if;
    logic       sin;
    logic       sck_rising_edge;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output sin,
        output sck_rising_edge,
        input  rx_data,
        input  rx_data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  sin,
        input  sck_rising_edge,
        output rx_data,
        output rx_data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on a shared 16x oversampling tick.
// Emits a one-cycle valid strobe per good byte, or a framing-error strobe.
module uart_receiver (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.slave  rx_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2,
        STOP   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] edges_q, edges_d;
    logic [2:0] bits_q, bits_d;
    logic [7:0] buf_q, buf_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    logic       sin_meta_q;
    logic       sin_sync_q;
    logic       sin_prev_q;
    logic       tick;
    logic       fall;

    // Flops reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_meta_q <= 1'b1;
            sin_sync_q <= 1'b1;
            sin_prev_q <= 1'b1;
        end else begin
            sin_meta_q <= rx_if.sin;
            sin_sync_q <= sin_meta_q;
            sin_prev_q <= sin_sync_q;
        end
    end

    assign tick = rx_if.sck_rising_edge;
    assign fall = sin_prev_q & ~sin_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            edges_q <= 4'd0;
            bits_q  <= 3'd0;
            buf_q   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edges_q <= edges_d;
            bits_q  <= bits_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        edges_d = edges_q;
        bits_d  = bits_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    edges_d = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (edges_q == 4'd7) begin
                        edges_d = 4'd0;
                        state_d = sin_sync_q ? IDLE : ACTIVE;
                    end else begin
                        edges_d = edges_q + 4'd1;
                    end
                end
            end
            ACTIVE: begin
                if (tick) begin
                    if (edges_q == 4'd15) begin
                        buf_d   = {sin_sync_q, buf_q[7:1]};
                        edges_d = 4'd0;
                        if (bits_q == 3'd7) begin
                            bits_d  = 3'd0;
                            state_d = STOP;
                        end else begin
                            bits_d = bits_q + 3'd1;
                        end
                    end else begin
                        edges_d = edges_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (edges_q == 4'd15) begin
                        edges_d = 4'd0;
                        state_d = IDLE;
                        // Leaving mid stop bit lets a back-to-back start edge be seen.
                        if (sin_sync_q) begin
                            data_d  = buf_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        edges_d = edges_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_data_valid = valid_q;
    assign rx_if.frame_error   = ferr_q;
    assign rx_if.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: table of frames
// plus hand-written glitch, back-to-back, break and reset sequences.
module tb_uart_receiver;

    logic clk;
    logic rst_n;

    uart_receiver_if rx_if ();

    uart_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (rx_if.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int fcnt     = 0;
    logic [7:0] rxq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x tick: one clk wide, every 4 clk
    initial begin
        rx_if.sck_rising_edge = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 rx_if.sck_rising_edge = 1'b1;
            @(posedge clk);
            #1 rx_if.sck_rising_edge = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_if.rx_data_valid) begin
                vcnt = vcnt + 1;
                rxq.push_back(rx_if.rx_data);
            end
            if (rx_if.frame_error)
                fcnt = fcnt + 1;
        end
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (rx_if.sck_rising_edge)
                k = k + 1;
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_if.sin = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit chk_busy);
        send_bit(1'b0);
        if (chk_busy)
            check("busy_in_frame", {31'd0, rx_if.busy}, 32'd1);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        send_bit(stop);
    endtask

    vec_t vecs[3];
    int v0, f0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h6B, 1'b1, 1, 0, 8'h6B};

        rx_if.sin = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_rx_data", {24'd0, rx_if.rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_if.rx_data_valid}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.frame_error}, 32'd0);
        check("rst_busy", {31'd0, rx_if.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(20);

        for (int i = 0; i < 3; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b1);
            rx_if.sin = 1'b1;
            wait_ticks(24);
            check("tbl_valid_cnt", vcnt - v0, vecs[i].exp_valid);
            check("tbl_ferr_cnt", fcnt - f0, vecs[i].exp_ferr);
            check("tbl_rx_data", {24'd0, rx_if.rx_data},
                  {24'd0, vecs[i].exp_data});
            check("tbl_busy_idle", {31'd0, rx_if.busy}, 32'd0);
        end

        // glitch shorter than half a bit
        v0 = vcnt;
        f0 = fcnt;
        rx_if.sin = 1'b0;
        wait_ticks(4);
        rx_if.sin = 1'b1;
        wait_ticks(2);
        check("glitch_busy_start", {31'd0, rx_if.busy}, 32'd1);
        wait_ticks(14);
        check("glitch_busy_drop", {31'd0, rx_if.busy}, 32'd0);
        wait_ticks(160);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_no_ferr", fcnt - f0, 0);

        // back-to-back frames, no idle gap
        rxq.delete();
        v0 = vcnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        rx_if.sin = 1'b1;
        wait_ticks(24);
        check("b2b_count", vcnt - v0, 2);
        if (rxq.size() == 2) begin
            check("b2b_first", {24'd0, rxq[0]}, 32'h00);
            check("b2b_second", {24'd0, rxq[1]}, 32'hFF);
        end else begin
            check("b2b_queue_size", rxq.size(), 2);
        end

        // break: line held low for 30 bit periods
        v0 = vcnt;
        f0 = fcnt;
        rx_if.sin = 1'b0;
        wait_ticks(30 * 16);
        check("brk_ferr", fcnt - f0, 1);
        check("brk_no_valid", vcnt - v0, 0);
        check("brk_busy_low", {31'd0, rx_if.busy}, 32'd0);
        rx_if.sin = 1'b1;
        wait_ticks(32);
        send_frame(8'h81, 1'b1, 1'b0);
        rx_if.sin = 1'b1;
        wait_ticks(24);
        check("brk_after_valid", vcnt - v0, 1);
        check("brk_after_ferr", fcnt - f0, 1);
        check("brk_after_data", {24'd0, rx_if.rx_data}, 32'h81);

        // reset mid-frame during data bit 4 of 0x55
        v0 = vcnt;
        f0 = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(i[0] ? 1'b0 : 1'b1);
        rx_if.sin = 1'b1;
        wait_ticks(8);
        check("mid_busy", {31'd0, rx_if.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, rx_if.busy}, 32'd0);
        check("mid_rst_data", {24'd0, rx_if.rx_data}, 32'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(200);
        check("mid_no_strobe", (vcnt - v0) + (fcnt - f0), 0);
        send_frame(8'h12, 1'b1, 1'b1);
        rx_if.sin = 1'b1;
        wait_ticks(24);
        check("post_rst_valid", vcnt - v0, 1);
        check("post_rst_data", {24'd0, rx_if.rx_data}, 32'h12);
        check("post_rst_ferr", fcnt - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
